// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect input and the IF/ID output slot.
// master = fetch unit side, slave = memory / pipeline side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr, imem_rsp_ready,
    output out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, imem_rsp_ready,
    input  out_valid, out_pc, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, one-entry output slot, redirect flush.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus,
    output logic [1:0]  dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    // Handshake rule: a transfer happens in any cycle where valid and ready are both
    // high at the rising clock edge; valid never depends on ready on the same channel.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pend_pc_q;
    logic        kill_q;
    logic        out_valid_q;
    logic [31:0] out_pc_q, out_instr_q;

    logic        req_valid, rsp_ready;
    logic        req_hs, rsp_hs, redir, capture, consume;

    assign req_hs  = (state_q == REQ) & bus.imem_req_ready;
    assign rsp_hs  = (state_q == WAIT) & bus.imem_rsp_valid & rsp_ready;
    assign redir   = bus.redirect_valid & (state_q != IDLE);
    assign capture = rsp_hs & ~kill_q & ~redir;
    assign consume = out_valid_q & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Redirect never changes the transition: accepted requests still need their response drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (req_hs) state_d = WAIT;
            WAIT:    if (rsp_hs) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_valid = (state_q == REQ);
        rsp_ready = (state_q == WAIT) & (kill_q | ~out_valid_q | bus.out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            pend_pc_q   <= RESET_PC;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0;
            out_instr_q <= NOP_INSTR;
        end else begin
            if (bus.redirect_valid)  pc_q <= {bus.redirect_pc[31:2], 2'b00};
            else if (req_hs)         pc_q <= pc_q + 32'd4;
            if (req_hs)              pend_pc_q <= pc_q;

            if (redir)               kill_q <= (state_q == REQ) ? (req_hs | kill_q) : ~rsp_hs;
            else if (rsp_hs)         kill_q <= 1'b0;

            if (redir) begin
                out_valid_q <= 1'b0;
                out_instr_q <= NOP_INSTR;
            end else if (capture) begin
                out_valid_q <= 1'b1;
                out_pc_q    <= pend_pc_q;
                out_instr_q <= bus.imem_rsp_data;
            end else if (consume) begin
                out_valid_q <= 1'b0;
                out_instr_q <= NOP_INSTR;
            end
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.imem_rsp_ready = rsp_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_instr      = out_instr_q;
    assign dbg_state          = state_q;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= 32'h0;
            perf_stall   <= 32'h0;
        end else begin
            if (capture && perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 32'd1;
            if (out_valid_q && !bus.out_ready && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
